icache_nway: RTL and testbench

- Parametrised N-way set-associative read-only instruction cache: controller FSM and datapath in one block.
- Generalises the fixed 2-way, 8-set instruction cache datapath to configurable ways and sets.
- Adds tree pseudo-LRU replacement, an internal fill FSM, and a multi-cycle flush (invalidate-all) sequence.
- Sits between the fetch stage (256-bit line read port) and the L2/arbiter line-fill port.

---
 rtl/icache_pkg.sv | 17 +
 rtl/icache_nway_plru_tree.sv | 59 +++++
 rtl/icache_nway.sv | 210 +++++++++++++++++++++
 tb/tb_icache_nway.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared types and defaults for the N-way instruction cache.
package icache_pkg;

    localparam int unsigned LINE_BITS    = 256;
    localparam int unsigned DEF_S_OFFSET = 5;
    localparam int unsigned DEF_S_INDEX  = 3;

    typedef logic [LINE_BITS-1:0] line_t;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        RESP,
        FLUSH
    } icache_state_t;

endpackage

// File: rtl/icache_nway_plru_tree.sv
// Tree pseudo-LRU helper: victim lookup and "point away from accessed way" update.
// Heap layout: node n has children 2n+1 / 2n+2; a bit value of 0 points to the lower half.
module plru_tree
    import icache_pkg::*;
#(
    parameter int unsigned num_ways = 4
) (
    input  logic [num_ways-2:0]         bits_i,
    input  logic [$clog2(num_ways)-1:0] access_way_i,
    output logic [$clog2(num_ways)-1:0] victim_o,
    output logic [num_ways-2:0]         next_bits_o
);

    localparam int unsigned WAY_W  = $clog2(num_ways);
    localparam int unsigned LEVELS = WAY_W;

    // Padded to num_ways entries so a WAY_W-bit node index addresses it exactly.
    logic [num_ways-1:0] tree;
    logic [num_ways-1:0] next_tree;
    logic [WAY_W-1:0]    vic_node;
    logic [WAY_W-1:0]    vic_prefix;
    logic [WAY_W-1:0]    upd_node;
    logic [WAY_W-1:0]    upd_prefix;
    logic [WAY_W-1:0]    upd_way;
    logic                upd_dir;
    logic                unused_pad;

    assign tree = {1'b0, bits_i};

    // NOTE: every variable assigned in an always_comb gets a default first, otherwise a latch is inferred.
    always_comb begin
        vic_node   = '0;
        vic_prefix = '0;
        for (int l = 0; l < LEVELS; l++) begin
            vic_node   = WAY_W'((1 << l) - 1) + vic_prefix;
            vic_prefix = (vic_prefix << 1) | WAY_W'(tree[vic_node]);
        end
        victim_o = vic_prefix;
    end

    always_comb begin
        next_tree  = tree;
        upd_node   = '0;
        upd_prefix = '0;
        upd_way    = access_way_i;
        upd_dir    = 1'b0;
        for (int l = 0; l < LEVELS; l++) begin
            upd_node            = WAY_W'((1 << l) - 1) + upd_prefix;
            upd_dir             = upd_way[WAY_W-1];
            next_tree[upd_node] = ~upd_dir;
            upd_prefix          = (upd_prefix << 1) | WAY_W'(upd_dir);
            upd_way             = upd_way << 1;
        end
    end

    assign next_bits_o = next_tree[num_ways-2:0];
    assign unused_pad  = next_tree[num_ways-1];

endmodule

// File: rtl/icache_nway.sv
// N-way set-associative read-only instruction cache with tree-PLRU, fill FSM and flush walk.
// Optional hit/miss counters are built when ICACHE_PERF_CNT_EN is defined.
module icache_nway
    import icache_pkg::*;
#(
    parameter int unsigned s_offset = DEF_S_OFFSET,
    parameter int unsigned s_index  = DEF_S_INDEX,
    parameter int unsigned num_ways = 4,
    parameter int unsigned s_tag    = 32 - s_offset - s_index
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_address,
    input  logic        mem_read,
    output line_t       mem_rdata256,
    output logic        mem_resp,
    input  logic        flush,
    output logic        busy,
    output logic [31:0] pmem_address,
    output logic        pmem_read,
    input  line_t       pmem_rdata,
    input  logic        pmem_resp,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    localparam int unsigned NUM_SETS = 1 << s_index;
    localparam int unsigned WAY_W    = $clog2(num_ways);
    localparam int unsigned LINE_W   = 32 - s_offset;

    icache_state_t state_q, state_d;

    logic [num_ways-1:0] valid_q [NUM_SETS];
    logic [num_ways-2:0] plru_q  [NUM_SETS];
    logic [s_tag-1:0]    tag_q   [NUM_SETS][num_ways];
    line_t               data_q  [NUM_SETS][num_ways];

    logic [LINE_W-1:0]  fill_line_q;
    logic [WAY_W-1:0]   victim_q;
    logic               keep_resp_q;
    logic               flush_pending_q;
    logic [s_index-1:0] flush_set_q;

    logic [s_index-1:0] req_set, fill_set, plru_set;
    logic [s_tag-1:0]   req_tag, fill_tag;
    logic [num_ways-1:0] way_match;
    logic [WAY_W-1:0]   hit_way, plru_victim, fill_victim, plru_access;
    logic [num_ways-2:0] plru_next;
    logic               hit, flush_go, fill_done, flush_last;
    logic               unused_offset;

    assign req_set       = mem_address[s_offset +: s_index];
    assign req_tag       = mem_address[31 -: s_tag];
    assign fill_set      = fill_line_q[s_index-1:0];
    assign fill_tag      = fill_line_q[LINE_W-1 -: s_tag];
    assign unused_offset = ^mem_address[s_offset-1:0];

    assign flush_go   = flush || flush_pending_q;
    assign fill_done  = (state_q == FILL) && pmem_resp;
    assign flush_last = (flush_set_q == s_index'(NUM_SETS - 1));

    always_comb begin
        way_match = '0;
        hit_way   = '0;
        for (int w = 0; w < num_ways; w++) begin
            way_match[w] = valid_q[req_set][w] && (tag_q[req_set][w] == req_tag);
            if (way_match[w]) hit_way = WAY_W'(w);
        end
    end
    assign hit = |way_match;

    // Descending scan so the lowest-numbered invalid way wins over the PLRU choice.
    always_comb begin
        fill_victim = plru_victim;
        for (int w = num_ways - 1; w >= 0; w--) begin
            if (!valid_q[req_set][w]) fill_victim = WAY_W'(w);
        end
    end

    assign plru_set    = (state_q == FILL) ? fill_set : req_set;
    assign plru_access = (state_q == FILL) ? victim_q : hit_way;

    plru_tree #(.num_ways(num_ways)) u_plru (
        .bits_i       (plru_q[plru_set]),
        .access_way_i (plru_access),
        .victim_o     (plru_victim),
        .next_bits_o  (plru_next)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (flush_go)           state_d = FLUSH;
                else if (mem_read && !hit) state_d = FILL;
            end
            FILL:    if (pmem_resp)  state_d = RESP;
            RESP:    state_d = IDLE;
            FLUSH:   if (flush_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_resp     = 1'b0;
        mem_rdata256 = data_q[req_set][hit_way];
        pmem_read    = 1'b0;
        busy         = 1'b0;
        unique case (state_q)
            IDLE: mem_resp = mem_read && hit && !flush_go;
            FILL: begin
                pmem_read = 1'b1;
                busy      = 1'b1;
            end
            RESP: begin
                busy         = 1'b1;
                mem_resp     = keep_resp_q;
                mem_rdata256 = data_q[fill_set][victim_q];
            end
            FLUSH:   busy = 1'b1;
            default: ;
        endcase
    end

    assign pmem_address = {fill_line_q, {s_offset{1'b0}}};

    always_ff @(posedge clk) begin
        if (rst) begin
            fill_line_q     <= '0;
            victim_q        <= '0;
            keep_resp_q     <= 1'b0;
            flush_pending_q <= 1'b0;
            flush_set_q     <= '0;
        end else begin
            if (state_q == IDLE && state_d == FILL) begin
                fill_line_q <= mem_address[31:s_offset];
                victim_q    <= fill_victim;
                keep_resp_q <= 1'b1;
            end
            // A fetch abandoned mid-fill still installs the line but gets no response.
            if (state_q == FILL && !mem_read) keep_resp_q <= 1'b0;
            if (state_q == IDLE && flush_go) begin
                flush_pending_q <= 1'b0;
                flush_set_q     <= '0;
            end else if (flush && (state_q == FILL || state_q == RESP)) begin
                flush_pending_q <= 1'b1;
            end
            if (state_q == FLUSH) flush_set_q <= flush_set_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else begin
            if (state_q == IDLE && mem_resp) plru_q[req_set] <= plru_next;
            if (fill_done) begin
                valid_q[fill_set][victim_q] <= 1'b1;
                plru_q[fill_set]            <= plru_next;
            end
            if (state_q == FLUSH) begin
                valid_q[flush_set_q] <= '0;
                if (flush_last) begin
                    for (int s = 0; s < NUM_SETS; s++) plru_q[s] <= '0;
                end
            end
        end
    end

    // NOTE: tag/data storage is deliberately not reset; the valid bits gate every use of it.
    always_ff @(posedge clk) begin
        if (!rst && fill_done) begin
            tag_q[fill_set][victim_q]  <= fill_tag;
            data_q[fill_set][victim_q] <= pmem_rdata;
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] hit_count_q, miss_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            if (state_q == IDLE && mem_resp)       hit_count_q  <= hit_count_q + 32'd1;
            if (state_q == IDLE && state_d == FILL) miss_count_q <= miss_count_q + 32'd1;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

    a_single_hit : assert property (@(posedge clk) disable iff (rst) $onehot0(way_match))
        else $error("icache_nway: more than one way matched the lookup tag");

endmodule

// File: tb/tb_icache_nway.sv
// Directed self-checking bench for icache_nway (default 4 ways, 8 sets, 32-byte lines).
module tb_icache_nway;
    import icache_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] mem_address = '0;
    logic        mem_read = 1'b0;
    line_t       mem_rdata256;
    logic        mem_resp;
    logic        flush = 1'b0;
    logic        busy;
    logic [31:0] pmem_address;
    logic        pmem_read;
    line_t       pmem_rdata = '0;
    logic        pmem_resp = 1'b0;
    logic [31:0] hit_count, miss_count;

    int n_checks = 0;
    int n_pass   = 0;

    icache_nway dut (
        .clk          (clk),
        .rst          (rst),
        .mem_address  (mem_address),
        .mem_read     (mem_read),
        .mem_rdata256 (mem_rdata256),
        .mem_resp     (mem_resp),
        .flush        (flush),
        .busy         (busy),
        .pmem_address (pmem_address),
        .pmem_read    (pmem_read),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp),
        .hit_count    (hit_count),
        .miss_count   (miss_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic line_t pat(input logic [31:0] k);
        return {8{32'hC0DE_0000 ^ k}};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; mem_read = 1'b0; flush = 1'b0; pmem_resp = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Miss: request cycle, then lat FILL cycles (pmem_resp in the last), then RESP.
    task automatic miss_read(input logic [31:0] addr, input line_t fill, input int lat,
                             input int flush_at, input string tag);
        logic [31:0] line_addr;
        line_addr = addr & 32'hFFFF_FFE0;
        @(negedge clk);
        mem_address = addr; mem_read = 1'b1;
        #1 check({tag, " req no resp"}, mem_resp, 1'b0);
        for (int i = 1; i <= lat; i++) begin
            @(negedge clk);
            flush = (i == flush_at);
            if (i == lat) begin
                pmem_rdata = fill;
                pmem_resp  = 1'b1;
            end
            #1;
            if (i == 1) begin
                check({tag, " pmem_read"}, pmem_read, 1'b1);
                check({tag, " pmem_address"}, pmem_address, line_addr);
                check({tag, " busy in fill"}, busy, 1'b1);
            end
        end
        @(negedge clk);
        flush = 1'b0; pmem_resp = 1'b0;
        #1;
        check({tag, " resp after fill"}, mem_resp, 1'b1);
        check({tag, " fill data"}, mem_rdata256, fill);
        check({tag, " pmem_read low in resp"}, pmem_read, 1'b0);
        @(negedge clk);
        mem_read = 1'b0;
    endtask

    task automatic hit_read(input logic [31:0] addr, input line_t exp, input string tag);
        @(negedge clk);
        mem_address = addr; mem_read = 1'b1;
        #1;
        check({tag, " hit resp"}, mem_resp, 1'b1);
        check({tag, " hit data"}, mem_rdata256, exp);
        check({tag, " no pmem_read"}, pmem_read, 1'b0);
        @(negedge clk);
        mem_read = 1'b0;
    endtask

    // Counts consecutive busy cycles, starting at the current negedge; bounded.
    task automatic wait_flush(input string tag);
        int  n    = 0;
        bit  seen = 1'b0;
        for (int i = 0; i < 24; i++) begin
            #1;
            if (busy) begin
                n++;
                seen = 1'b1;
            end else if (seen) begin
                break;
            end
            @(negedge clk);
        end
        check(tag, n, 8);
    endtask

    // Set 2 (address bits [7:5] = 2), distinct tags.
    localparam logic [31:0] A = 32'h0000_0140;
    localparam logic [31:0] B = 32'h0000_0240;
    localparam logic [31:0] C = 32'h0000_0340;
    localparam logic [31:0] D = 32'h0000_0440;
    localparam logic [31:0] E = 32'h0000_0540;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int exp_hits, exp_misses;

        // Reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset busy", busy, 1'b0);
        check("reset mem_resp", mem_resp, 1'b0);
        check("reset pmem_read", pmem_read, 1'b0);
        check("reset hit_count", hit_count, 32'd0);
        check("reset miss_count", miss_count, 32'd0);

        // Cold miss then zero-wait reread
        miss_read(32'h0000_1040, {32{8'hA5}}, 3, 0, "cold");
        hit_read(32'h0000_1040, {32{8'hA5}}, "reread");

        // Fill set 2: invalid-first A..D in ways 0..3; PLRU after touching A picks way 2 (C)
        do_reset();
        miss_read(A, pat(1), 2, 0, "fillA");
        miss_read(B, pat(2), 2, 0, "fillB");
        miss_read(C, pat(3), 2, 0, "fillC");
        miss_read(D, pat(4), 2, 0, "fillD");
        hit_read(A, pat(1), "touchA");
        miss_read(E, pat(5), 2, 0, "fillE");
        hit_read(A, pat(1), "A kept");
        hit_read(B, pat(2), "B kept");
        hit_read(D, pat(4), "D kept");
        hit_read(E, pat(5), "E present");
        miss_read(C, pat(3), 2, 0, "C evicted");

        // Flush in IDLE wins over a simultaneous read of a cached line
        @(negedge clk);
        mem_address = E; mem_read = 1'b1; flush = 1'b1;
        #1 check("flush priority no resp", mem_resp, 1'b0);
        @(negedge clk);
        flush = 1'b0; mem_read = 1'b0;
        wait_flush("flush idle busy cycles");
        miss_read(A, pat(11), 2, 0, "A after flush");
        miss_read(E, pat(15), 2, 0, "E after flush");

        // Flush during fill: miss responds, then the flush walk runs
        miss_read(32'h0000_3060, pat(20), 3, 2, "fill+flush");
        wait_flush("pending flush busy cycles");
        miss_read(32'h0000_3060, pat(21), 2, 0, "refill after flush");

        // mem_read dropped in FILL: line installed, no response
        @(negedge clk);
        mem_address = 32'h0000_5080; mem_read = 1'b1;
        #1 check("drop req no resp", mem_resp, 1'b0);
        @(negedge clk);
        mem_read = 1'b0;
        @(negedge clk);
        pmem_rdata = pat(30); pmem_resp = 1'b1;
        @(negedge clk);
        pmem_resp = 1'b0;
        #1;
        check("drop no resp in RESP", mem_resp, 1'b0);
        check("drop busy in RESP", busy, 1'b1);
        hit_read(32'h0000_5080, pat(30), "dropped line installed");

        // Reset one cycle into FILL, then a late pmem_resp
        @(negedge clk);
        mem_address = 32'h0000_70A0; mem_read = 1'b1;
        @(negedge clk);
        #1 check("rst-fill pmem_read before rst", pmem_read, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; mem_read = 1'b0;
        pmem_rdata = pat(40); pmem_resp = 1'b1;
        #1;
        check("rst-fill pmem_read dropped", pmem_read, 1'b0);
        check("rst-fill no resp", mem_resp, 1'b0);
        check("rst-fill not busy", busy, 1'b0);
        @(negedge clk);
        pmem_resp = 1'b0;
        miss_read(32'h0000_70A0, pat(41), 2, 0, "rst-fill still misses");

        // Counters: 3 misses and 5 hits, unaffected by flush
        do_reset();
        miss_read(32'h0000_2000, pat(50), 2, 0, "cnt X");
        hit_read(32'h0000_2000, pat(50), "cnt X h1");
        hit_read(32'h0000_2000, pat(50), "cnt X h2");
        miss_read(32'h0000_2020, pat(51), 2, 0, "cnt Y");
        hit_read(32'h0000_2020, pat(51), "cnt Y h");
        miss_read(32'h0000_2040, pat(52), 2, 0, "cnt Z");
        hit_read(32'h0000_2040, pat(52), "cnt Z h");
        hit_read(32'h0000_2000, pat(50), "cnt X h3");
`ifdef ICACHE_PERF_CNT_EN
        exp_hits = 5; exp_misses = 3;
`else
        exp_hits = 0; exp_misses = 0;
`endif
        @(negedge clk);
        #1;
        check("hit_count", hit_count, 32'(exp_hits));
        check("miss_count", miss_count, 32'(exp_misses));
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        wait_flush("cnt flush busy cycles");
        check("hit_count after flush", hit_count, 32'(exp_hits));
        check("miss_count after flush", miss_count, 32'(exp_misses));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
